// File: rtl/final_layer_seq_param.sv
// final_layer_seq_param: sequential BNN output layer.
// Scores every class as popcount(XNOR(data_in, weights_in[c])), CHUNK bits per
// cycle for all classes in parallel, then walks the scores one class per cycle
// to find the argmax and registers the winning class index.
// Optional build macro FINAL_LAYER_SCORE_OUT_EN adds best_score/score_valid.
//
// Control contract: en is a level enable. en=1 in IDLE starts a run; en must
// stay high (and data_in/weights_in stable) while busy, otherwise the run is
// aborted back to IDLE. layer_3_done is a one-cycle pulse while in DONE, and
// en=1 in DONE starts the next run immediately.
module final_layer_seq_param #(
  parameter int NUM_INPUTS  = 196,
  parameter int NUM_CLASSES = 10,
  parameter int CHUNK       = 14,
  localparam int N_CHUNKS   = (NUM_INPUTS + CHUNK - 1) / CHUNK,
  localparam int SCORE_W    = $clog2(NUM_INPUTS + 1),
  localparam int CLASS_W    = $clog2(NUM_CLASSES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NUM_INPUTS-1:0] data_in,
  input  logic [NUM_INPUTS-1:0] weights_in [NUM_CLASSES-1:0],
  output logic [CLASS_W-1:0]    answer_reg,
  output logic                  layer_3_done,
  output logic                  busy,
  output logic [1:0]            state_dbg
`ifdef FINAL_LAYER_SCORE_OUT_EN
  ,
  output logic [SCORE_W-1:0]    best_score,
  output logic                  score_valid
`endif
);

  localparam int PAD_W   = N_CHUNKS * CHUNK;
  localparam int MAX_CNT = (N_CHUNKS > NUM_CLASSES) ? N_CHUNKS : NUM_CLASSES;
  localparam int CNT_W   = $clog2(MAX_CNT);
  // Bits at or above NUM_INPUTS in the last chunk are padding and never score.
  localparam logic [PAD_W-1:0] VALID_PAD = PAD_W'({NUM_INPUTS{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_ARGMAX = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q [NUM_CLASSES];
  logic [SCORE_W-1:0] score_d [NUM_CLASSES];
  logic [CLASS_W-1:0] best_idx_q, best_idx_d;
  logic [SCORE_W-1:0] best_sc_q, best_sc_d;
  logic [CLASS_W-1:0] answer_q, answer_d;

  logic [PAD_W-1:0]   xn_pad     [NUM_CLASSES];
  logic [CHUNK-1:0]   chunk_bits [NUM_CLASSES];
  logic [SCORE_W-1:0] chunk_pop  [NUM_CLASSES];
  logic [SCORE_W-1:0] cur_sc;
  logic [CLASS_W-1:0] win_idx;
  logic [SCORE_W-1:0] win_sc;
  logic               last_chunk;
  logic               last_class;
  logic               load_result;

  assign last_chunk = (cnt_q == CNT_W'(N_CHUNKS - 1));
  assign last_class = (cnt_q == CNT_W'(NUM_CLASSES - 1));

  // Per-class popcount of the XNOR match bits in the chunk selected by cnt_q.
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      xn_pad[c]     = ~(PAD_W'(data_in) ^ PAD_W'(weights_in[c])) & VALID_PAD;
      chunk_bits[c] = '0;
      for (int k = 0; k < N_CHUNKS; k++) begin
        if (cnt_q == CNT_W'(k)) chunk_bits[c] = xn_pad[c][k*CHUNK +: CHUNK];
      end
      chunk_pop[c] = '0;
      for (int b = 0; b < CHUNK; b++) begin
        chunk_pop[c] = chunk_pop[c] + SCORE_W'(chunk_bits[c][b]);
      end
    end
  end

  // Running argmax step: class 0 seeds the best, later classes win only on a strictly larger score.
  always_comb begin
    cur_sc = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (cnt_q == CNT_W'(c)) cur_sc = score_q[c];
    end
    win_idx = best_idx_q;
    win_sc  = best_sc_q;
    if ((cnt_q == '0) || (cur_sc > best_sc_q)) begin
      win_idx = CLASS_W'(cnt_q);
      win_sc  = cur_sc;
    end
  end

  // Next-state and datapath update; en low while busy aborts without touching the answer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_d     = score_q;
    best_idx_d  = best_idx_q;
    best_sc_d   = best_sc_q;
    answer_d    = answer_q;
    load_result = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        for (int c = 0; c < NUM_CLASSES; c++) score_d[c] = '0;
        if (en) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (!en) begin
          state_d = S_IDLE;
        end else begin
          for (int c = 0; c < NUM_CLASSES; c++) score_d[c] = score_q[c] + chunk_pop[c];
          if (last_chunk) begin
            cnt_d   = '0;
            state_d = S_ARGMAX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ARGMAX: begin
        if (!en) begin
          state_d = S_IDLE;
        end else begin
          best_idx_d = win_idx;
          best_sc_d  = win_sc;
          if (last_class) begin
            answer_d    = win_idx;
            load_result = 1'b1;
            cnt_d       = '0;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        cnt_d = '0;
        for (int c = 0; c < NUM_CLASSES; c++) score_d[c] = '0;
        state_d = en ? S_ACCUM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: chunk/class counter, score accumulators, argmax tracker, answer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_sc_q  <= '0;
      answer_q   <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) score_q[c] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      best_idx_q <= best_idx_d;
      best_sc_q  <= best_sc_d;
      answer_q   <= answer_d;
      for (int c = 0; c < NUM_CLASSES; c++) score_q[c] <= score_d[c];
    end
  end

  assign answer_reg   = answer_q;
  assign layer_3_done = (state_q == S_DONE);
  assign busy         = (state_q == S_ACCUM) || (state_q == S_ARGMAX);
  assign state_dbg    = state_q;

`ifdef FINAL_LAYER_SCORE_OUT_EN
  logic [SCORE_W-1:0] best_score_q;

  // Winning score, captured on the same edge as answer_reg.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)           best_score_q <= '0;
    else if (load_result) best_score_q <= win_sc;
  end

  assign best_score  = best_score_q;
  assign score_valid = layer_3_done;
`else
  // Without the score port the winning score is only needed internally.
  logic unused_load;
  assign unused_load = load_result;
`endif

endmodule

// File: tb/tb_final_layer_seq_param.sv
// Bench for final_layer_seq_param: default-parameter instance plus a small
// partial-chunk instance (20 inputs, chunk 8, 3 classes).
module tb_final_layer_seq_param;

  localparam int NI     = 196;
  localparam int NC     = 10;
  localparam int LAT    = 24;
  localparam int PERIOD = 25;
  localparam int P_NI   = 20;
  localparam int P_NC   = 3;
  localparam int P_CK   = 8;
  localparam int P_LAT  = 6;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          en;
  logic [NI-1:0] data;
  logic [NI-1:0] weights [NC-1:0];
  logic [3:0]    answer_reg;
  logic          done;
  logic          busy;
  logic [1:0]    state_dbg;

  logic            p_en;
  logic [P_NI-1:0] p_data;
  logic [P_NI-1:0] p_weights [P_NC-1:0];
  logic [1:0]      p_answer;
  logic            p_done;
  logic            p_busy;
  logic [1:0]      p_state;

`ifdef FINAL_LAYER_SCORE_OUT_EN
  logic [7:0] best_score;
  logic       score_valid;
  logic [4:0] p_best;
  logic       p_valid;
`endif

  final_layer_seq_param u_dut (
    .clock(clock), .reset(reset), .en(en), .data_in(data), .weights_in(weights),
    .answer_reg(answer_reg), .layer_3_done(done), .busy(busy), .state_dbg(state_dbg)
`ifdef FINAL_LAYER_SCORE_OUT_EN
    , .best_score(best_score), .score_valid(score_valid)
`endif
  );

  final_layer_seq_param #(.NUM_INPUTS(P_NI), .NUM_CLASSES(P_NC), .CHUNK(P_CK)) u_part (
    .clock(clock), .reset(reset), .en(p_en), .data_in(p_data), .weights_in(p_weights),
    .answer_reg(p_answer), .layer_3_done(p_done), .busy(p_busy), .state_dbg(p_state)
`ifdef FINAL_LAYER_SCORE_OUT_EN
    , .best_score(p_best), .score_valid(p_valid)
`endif
  );

  int checks = 0;
  int passes = 0;

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  logic [7:0] exp_s_q[$];

  // Reference: count matching bits per class, keep the first maximum.
  function automatic void model(input logic [NI-1:0] d, input logic [NI-1:0] w [NC-1:0],
                                input int ni, input int nc, output int ans, output int best);
    int sc;
    ans  = 0;
    best = -1;
    for (int c = 0; c < nc; c++) begin
      sc = 0;
      for (int i = 0; i < ni; i++) if (d[i] == w[c][i]) sc++;
      if (sc > best) begin
        best = sc;
        ans  = c;
      end
    end
  endfunction

  function automatic void push_expected();
    int a, s;
    model(data, weights, NI, NC, a, s);
    exp_q.push_back(4'(a));
    exp_s_q.push_back(8'(s));
  endfunction

  function automatic void push_expected_part();
    logic [NI-1:0] md;
    logic [NI-1:0] mw [NC-1:0];
    int a, s;
    md = NI'(p_data);
    for (int c = 0; c < NC; c++) mw[c] = (c < P_NC) ? NI'(p_weights[c]) : '0;
    model(md, mw, P_NI, P_NC, a, s);
    exp_q.push_back(4'(a));
    exp_s_q.push_back(8'(s));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_vec(output logic [NI-1:0] v);
    for (int i = 0; i < NI; i++) v[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_all();
    rand_vec(data);
    for (int c = 0; c < NC; c++) rand_vec(weights[c]);
  endtask

  // Counts edges until the done pulse is seen, giving up after budget edges.
  task automatic wait_done(input bit part, input int budget, output int edges, output bit seen);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < budget) begin
      tick();
      edges++;
      if ((part ? p_done : done) === 1'b1) seen = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    en = 1'b0; p_en = 1'b0;
    data = '0; p_data = '0;
    for (int c = 0; c < NC; c++) weights[c] = '0;
    for (int c = 0; c < P_NC; c++) p_weights[c] = '0;
    #12;
    checks++; if (answer_reg !== 4'd0) $display("FAIL reset_answer: got %0d expected 0", answer_reg); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (p_answer !== 2'd0) $display("FAIL reset_part_answer: got %0d expected 0", p_answer); else passes++;
`ifdef FINAL_LAYER_SCORE_OUT_EN
    checks++; if (best_score !== 8'd0) $display("FAIL reset_best_score: got %0d expected 0", best_score); else passes++;
`endif
    #2;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int e; bit seen; logic [3:0] ea; logic [7:0] es;
    data = '1;
    for (int c = 0; c < NC; c++) weights[c] = '0;
    weights[4] = '1;
    push_expected();
    en = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b expected 1", busy); else passes++;
    wait_done(1'b0, LAT + 10, e, seen);
    checks++; if (!seen || e != LAT) $display("FAIL basic_latency: got %0d edges (seen=%0b) expected %0d", e, seen, LAT); else passes++;
    ea = exp_q.pop_front(); es = exp_s_q.pop_front();
    checks++; if (answer_reg !== ea) $display("FAIL basic_answer: got %0d expected %0d", answer_reg, ea); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_done: got %b expected 0", busy); else passes++;
`ifdef FINAL_LAYER_SCORE_OUT_EN
    checks++; if (best_score !== es) $display("FAIL basic_best_score: got %0d expected %0d", best_score, es); else passes++;
    checks++; if (score_valid !== 1'b1) $display("FAIL basic_score_valid: got %b expected 1", score_valid); else passes++;
`endif
    en = 1'b0;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_pulse_width: done=%b busy=%b expected 0 0", done, busy); else passes++;
    tick();
    checks++; if (answer_reg !== ea) $display("FAIL basic_answer_hold: got %0d expected %0d", answer_reg, ea); else passes++;
  endtask

  task automatic test_continuous();
    int e; bit seen; logic [3:0] ea; logic [7:0] es;
    rand_all();
    push_expected();
    en = 1'b1;
    tick();
    wait_done(1'b0, LAT + 10, e, seen);
    checks++; if (!seen || e != LAT) $display("FAIL cont_first_latency: got %0d edges expected %0d", e, LAT); else passes++;
    ea = exp_q.pop_front(); es = exp_s_q.pop_front();
    checks++; if (answer_reg !== ea) $display("FAIL cont_first_answer: got %0d expected %0d", answer_reg, ea); else passes++;
    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin
        data = '1;
        for (int c = 0; c < NC; c++) begin
          weights[c] = '0;
          for (int b = 0; b <= c; b++) weights[c][b] = 1'b1;
        end
      end else begin
        rand_all();
      end
      push_expected();
      wait_done(1'b0, PERIOD + 10, e, seen);
      checks++; if (!seen || e != PERIOD) $display("FAIL cont_period_%0d: got %0d cycles expected %0d", r, e, PERIOD); else passes++;
      ea = exp_q.pop_front(); es = exp_s_q.pop_front();
      checks++; if (answer_reg !== ea) $display("FAIL cont_answer_%0d: got %0d expected %0d", r, answer_reg, ea); else passes++;
`ifdef FINAL_LAYER_SCORE_OUT_EN
      checks++; if (best_score !== es) $display("FAIL cont_best_score_%0d: got %0d expected %0d", r, best_score, es); else passes++;
`endif
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_tie();
    int e; bit seen; int a, b; logic [3:0] ea; logic [7:0] es;
    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin
        data = '1;
        for (int c = 0; c < NC; c++) weights[c] = '0;
        weights[2] = '1;
        weights[7] = '1;
      end else begin
        rand_all();
        a = $urandom_range(0, 8);
        b = $urandom_range(a + 1, 9);
        weights[a] = data;
        weights[b] = data;
      end
      push_expected();
      en = 1'b1;
      tick();
      wait_done(1'b0, LAT + 10, e, seen);
      ea = exp_q.pop_front(); es = exp_s_q.pop_front();
      checks++; if (!seen || answer_reg !== ea) $display("FAIL tie_answer_%0d: got %0d (seen=%0b) expected %0d", r, answer_reg, seen, ea); else passes++;
      en = 1'b0;
      tick();
    end
  endtask

  task automatic test_random();
    int e; bit seen; logic [3:0] ea; logic [7:0] es;
    for (int r = 0; r < 6; r++) begin
      rand_all();
      push_expected();
      en = 1'b1;
      tick();
      wait_done(1'b0, LAT + 10, e, seen);
      ea = exp_q.pop_front(); es = exp_s_q.pop_front();
      checks++; if (!seen || answer_reg !== ea) $display("FAIL random_answer_%0d: got %0d (seen=%0b) expected %0d", r, answer_reg, seen, ea); else passes++;
`ifdef FINAL_LAYER_SCORE_OUT_EN
      checks++; if (best_score !== es) $display("FAIL random_best_score_%0d: got %0d expected %0d", r, best_score, es); else passes++;
`endif
      en = 1'b0;
      tick();
    end
  endtask

  task automatic test_abort();
    int e; bit seen; int pulses; int drop_after; logic [3:0] ea; logic [7:0] es;
    data = '1;
    for (int c = 0; c < NC; c++) weights[c] = '0;
    weights[3] = '1;
    push_expected();
    en = 1'b1;
    tick();
    wait_done(1'b0, LAT + 10, e, seen);
    ea = exp_q.pop_front(); es = exp_s_q.pop_front();
    checks++; if (!seen || answer_reg !== ea) $display("FAIL abort_setup_answer: got %0d expected %0d", answer_reg, ea); else passes++;
    en = 1'b0;
    tick();
    weights[3] = '0;
    weights[8] = '1;
    for (int k = 0; k < 2; k++) begin
      drop_after = (k == 0) ? 4 : 16;
      en = 1'b1;
      tick();
      repeat (drop_after) tick();
      en = 1'b0;
      pulses = 0;
      repeat (30) begin
        tick();
        if (done === 1'b1) pulses++;
      end
      checks++; if (pulses != 0) $display("FAIL abort_no_done_%0d: got %0d pulses expected 0", k, pulses); else passes++;
      checks++; if (answer_reg !== ea) $display("FAIL abort_answer_kept_%0d: got %0d expected %0d", k, answer_reg, ea); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL abort_busy_%0d: got %b expected 0", k, busy); else passes++;
    end
    push_expected();
    en = 1'b1;
    tick();
    wait_done(1'b0, LAT + 10, e, seen);
    checks++; if (!seen || e != LAT) $display("FAIL abort_rerun_latency: got %0d edges expected %0d", e, LAT); else passes++;
    ea = exp_q.pop_front(); es = exp_s_q.pop_front();
    checks++; if (answer_reg !== ea) $display("FAIL abort_rerun_answer: got %0d expected %0d", answer_reg, ea); else passes++;
    en = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int e; bit seen; logic [3:0] ea; logic [7:0] es;
    data = '1;
    for (int c = 0; c < NC; c++) weights[c] = '0;
    weights[5] = '1;
    push_expected();
    en = 1'b1;
    tick();
    wait_done(1'b0, LAT + 10, e, seen);
    ea = exp_q.pop_front(); es = exp_s_q.pop_front();
    checks++; if (!seen || answer_reg !== ea) $display("FAIL areset_setup_answer: got %0d expected %0d", answer_reg, ea); else passes++;
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    repeat (16) tick();
    checks++; if (busy !== 1'b1) $display("FAIL areset_pre_busy: got %b expected 1", busy); else passes++;
    #3;
    reset = 1'b0;
    #1;
    checks++; if (answer_reg !== 4'd0) $display("FAIL areset_answer: got %0d expected 0", answer_reg); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL areset_busy: got %b expected 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL areset_done: got %b expected 0", done); else passes++;
    en = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (answer_reg !== 4'd0) $display("FAIL areset_answer_idle: got %0d expected 0", answer_reg); else passes++;
    rand_all();
    push_expected();
    en = 1'b1;
    tick();
    wait_done(1'b0, LAT + 10, e, seen);
    ea = exp_q.pop_front(); es = exp_s_q.pop_front();
    checks++; if (!seen || e != LAT || answer_reg !== ea) $display("FAIL areset_recover: edges=%0d answer=%0d expected edges=%0d answer=%0d", e, answer_reg, LAT, ea); else passes++;
    en = 1'b0;
    tick();
  endtask

  task automatic test_partial();
    int e; bit seen; logic [3:0] ea; logic [7:0] es;
    for (int r = 0; r < 5; r++) begin
      if (r == 0) begin
        p_data = '0;
        p_weights[0] = '1;
        p_weights[1] = '0;
        p_weights[2] = '1;
      end else begin
        p_data = P_NI'($urandom);
        for (int c = 0; c < P_NC; c++) p_weights[c] = P_NI'($urandom);
      end
      push_expected_part();
      p_en = 1'b1;
      tick();
      wait_done(1'b1, P_LAT + 10, e, seen);
      checks++; if (!seen || e != P_LAT) $display("FAIL part_latency_%0d: got %0d edges expected %0d", r, e, P_LAT); else passes++;
      ea = exp_q.pop_front(); es = exp_s_q.pop_front();
      checks++; if (4'(p_answer) !== ea) $display("FAIL part_answer_%0d: got %0d expected %0d", r, p_answer, ea); else passes++;
`ifdef FINAL_LAYER_SCORE_OUT_EN
      checks++; if (8'(p_best) !== es) $display("FAIL part_best_score_%0d: got %0d expected %0d", r, p_best, es); else passes++;
      checks++; if (p_valid !== 1'b1) $display("FAIL part_score_valid_%0d: got %b expected 1", r, p_valid); else passes++;
`endif
      p_en = 1'b0;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_continuous();
    test_tie();
    test_random();
    test_abort();
    test_async_reset();
    test_partial();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
